// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the Jac1-8 fetch path.
package cpu_pkg;

    localparam int PC_WIDTH_DEF = 8;
    localparam int PC_RESET_VEC = 0;

    typedef enum logic [1:0] {
        HOLD,
        INC,
        LOAD,
        REL
    } pc_src_e;

endpackage

// File: rtl/pc_next_logic.sv
// pc_next_logic: combinational next-pc selection (hold, increment, load, relative add).
// Relative add exists only when PC_RELATIVE_EN is defined; otherwise add_offset is ignored.
module pc_next_logic
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [PC_WIDTH-1:0] i_addr,
    input  logic                i_wr_en,
    input  logic                i_add_offset,
    input  logic                i_run,
    output logic [PC_WIDTH-1:0] o_next_pc
);

    pc_src_e w_src;

`ifdef PC_RELATIVE_EN
    assign w_src = !i_run ? HOLD : !i_wr_en ? INC : i_add_offset ? REL : LOAD;
`else
    logic w_unused_add_offset;
    assign w_unused_add_offset = i_add_offset;
    assign w_src = !i_run ? HOLD : i_wr_en ? LOAD : INC;
`endif

    // additions wrap modulo 2^PC_WIDTH, so a two's-complement offset branches backward
    always_comb begin
        o_next_pc = i_pc;
        case (w_src)
            INC:     o_next_pc = i_pc + PC_WIDTH'(1);
            LOAD:    o_next_pc = i_addr;
`ifdef PC_RELATIVE_EN
            REL:     o_next_pc = i_pc + i_addr;
`endif
            default: o_next_pc = i_pc;
        endcase
    end

endmodule

// File: rtl/program_counter.sv
// program_counter: Jac1-8 fetch address register with a one-cycle start-up hold after reset.
// Relative jumps are built only with PC_RELATIVE_EN defined.
module program_counter
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                res,
    input  logic                wr_en,
    input  logic                add_offset,
    input  logic [PC_WIDTH-1:0] counteradress,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_run;
    logic [PC_WIDTH-1:0] w_next_pc;

    pc_next_logic #(.PC_WIDTH(PC_WIDTH)) u_next (
        .i_pc         (r_pc),
        .i_addr       (counteradress),
        .i_wr_en      (wr_en),
        .i_add_offset (add_offset),
        .i_run        (r_run),
        .o_next_pc    (w_next_pc)
    );

    // the first edge after reset only raises r_run, so address 0 is fetched twice
    always_ff @(posedge clk) begin
        if (res) begin
            r_pc  <= PC_WIDTH'(PC_RESET_VEC);
            r_run <= 1'b0;
        end else begin
            r_pc  <= w_next_pc;
            r_run <= 1'b1;
        end
    end

    assign pc = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed table plus randomized run against a reference model.
module tb_program_counter;

`ifdef PC_RELATIVE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    typedef struct {
        bit         res;
        bit         wr;
        bit         ao;
        logic [7:0] addr;
        logic [7:0] exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       wr_en = 1'b0;
    logic       add_offset = 1'b0;
    logic [7:0] counteradress = 8'd0;
    logic [7:0] pc;

    int n_checks = 0;
    int n_fail = 0;

    program_counter #(.PC_WIDTH(8)) dut (
        .clk           (clk),
        .res           (res),
        .wr_en         (wr_en),
        .add_offset    (add_offset),
        .counteradress (counteradress),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    task automatic step(input bit r, input bit w, input bit a, input logic [7:0] c,
                        input logic [7:0] exp, input string name);
        res = r;
        wr_en = w;
        add_offset = a;
        counteradress = c;
        @(posedge clk);
        #1;
        n_checks++;
        if (pc !== exp) begin
            n_fail++;
            $display("FAIL %s: pc=%0d expected %0d", name, pc, exp);
        end
    endtask

    vec_t vecs[19];

    int  m_pc;
    bit  m_run;
    bit  r_r, r_w, r_a;
    int  r_c;

    initial begin
        vecs[0]  = '{1, 0, 0, 8'd0,   8'd0,   "reset0"};
        vecs[1]  = '{1, 0, 0, 8'd0,   8'd0,   "reset1"};
        vecs[2]  = '{0, 1, 1, 8'd77,  8'd0,   "startup_hold"};
        vecs[3]  = '{0, 0, 0, 8'd0,   8'd1,   "inc1"};
        vecs[4]  = '{0, 0, 0, 8'd0,   8'd2,   "inc2"};
        vecs[5]  = '{0, 1, 0, 8'd32,  8'd32,  "abs_jump"};
        vecs[6]  = '{0, 0, 0, 8'd0,   8'd33,  "after_abs"};
        vecs[7]  = '{0, 1, 1, 8'd8,   REL_EN ? 8'd41 : 8'd8,   "rel_fwd"};
        vecs[8]  = '{0, 0, 0, 8'd0,   REL_EN ? 8'd42 : 8'd9,   "after_rel"};
        vecs[9]  = '{0, 1, 0, 8'd33,  8'd33,  "load33"};
        vecs[10] = '{0, 1, 1, 8'hF8,  REL_EN ? 8'd25 : 8'hF8,  "rel_back"};
        vecs[11] = '{0, 1, 0, 8'd255, 8'd255, "load255"};
        vecs[12] = '{0, 0, 0, 8'd0,   8'd0,   "wrap"};
        vecs[13] = '{0, 0, 1, 8'd200, 8'd1,   "ao_dont_care"};
        vecs[14] = '{0, 1, 0, 8'd41,  8'd41,  "load41"};
        vecs[15] = '{1, 1, 0, 8'd99,  8'd0,   "mid_reset"};
        vecs[16] = '{0, 1, 0, 8'd99,  8'd0,   "restart_hold"};
        vecs[17] = '{0, 0, 0, 8'd0,   8'd1,   "restart_inc1"};
        vecs[18] = '{0, 0, 0, 8'd0,   8'd2,   "restart_inc2"};

        #2;
        for (int i = 0; i < 19; i++)
            step(vecs[i].res, vecs[i].wr, vecs[i].ao, vecs[i].addr, vecs[i].exp, vecs[i].name);

        // long increment sequence through the top of the address space
        step(0, 1, 0, 8'd250, 8'd250, "seq_load250");
        for (int i = 1; i <= 8; i++)
            step(0, 0, 0, 8'd0, 8'((250 + i) % 256), "seq_wrap");

        // randomized run: model state picks up from the known pc above
        m_pc = 2;
        m_run = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r_r = ($urandom_range(0, 19) == 0);
            r_w = ($urandom_range(0, 2) == 0);
            r_a = $urandom_range(0, 1) == 1;
            r_c = $urandom_range(0, 255);
            if (r_r) begin
                m_pc = 0;
                m_run = 1'b0;
            end else if (!m_run) begin
                m_run = 1'b1;
            end else if (r_w && r_a && REL_EN) begin
                m_pc = (m_pc + r_c) % 256;
            end else if (r_w) begin
                m_pc = r_c;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
            step(r_r, r_w, r_a, 8'(r_c), 8'(m_pc), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
